// File: rtl/led_fader_pkg.sv
// Shared types for the LED fader: default brightness width and the per-channel fade direction.
package led_fader_pkg;

    localparam int DEF_PWM_BITS = 8;

    typedef logic [DEF_PWM_BITS-1:0] brightness_t;

    localparam brightness_t MAX_BRIGHTNESS = '1;

    typedef enum logic [1:0] {
        IDLE,
        RISING,
        FALLING
    } fade_dir_e;

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: brightness register with saturating linear fade, PWM compare and output flop.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int FADE_STEP = 8
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_tick,
    input  logic                i_enable,
    input  logic                i_led,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led,
    output logic                o_pending
);

    localparam logic [PWM_BITS-1:0] MAX   = '1;
    localparam logic [PWM_BITS:0]   MAX_W = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP  = (PWM_BITS+1)'(FADE_STEP);

    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] tgt;
    logic                led_q, led_d;
    fade_dir_e           dir;

    // One extra bit of headroom so the rising sum cannot wrap before clamping.
    function automatic logic [PWM_BITS-1:0] step_sat(input logic [PWM_BITS-1:0] b,
                                                     input fade_dir_e d);
        logic [PWM_BITS:0] wide;
        wide = {1'b0, b};
        case (d)
            RISING: begin
                wide = wide + STEP;
                if (wide > MAX_W) wide = MAX_W;
            end
            FALLING: begin
                if (wide < STEP) wide = '0;
                else             wide = wide - STEP;
            end
            default: ;
        endcase
        return wide[PWM_BITS-1:0];
    endfunction

    always_comb begin
        tgt = i_led ? MAX : '0;
        dir = IDLE;
        if (bright_q < tgt)      dir = RISING;
        else if (bright_q > tgt) dir = FALLING;

        bright_d = bright_q;
        if (!i_enable)   bright_d = tgt;
        else if (i_tick) bright_d = step_sat(bright_q, dir);

        led_d = i_enable ? ((bright_q == MAX) | (bright_q > i_pwm_cnt)) : i_led;
    end

    assign o_pending = (dir != IDLE);
    assign o_led     = led_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bright_q <= '0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: rtl/led_fader.sv
// LED fader top: shared fade-tick prescaler and PWM counter feeding N_LEDS fading channels.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int N_LEDS    = 10,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int STEP_DIV  = 4096,
    parameter int FADE_STEP = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [N_LEDS-1:0] i_leds,
    input  logic              i_enable,
    output logic [N_LEDS-1:0] o_ledr,
    output logic              o_busy
);

    localparam int                 PRESC_W    = $clog2(STEP_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                busy_q, busy_d;
    logic                tick;
    logic [N_LEDS-1:0]   pending;

    // Prescaler and PWM counter run regardless of i_enable so mode switches stay glitch-free.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        busy_d    = |pending;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign o_busy = busy_q;

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_tick    (tick),
            .i_enable  (i_enable),
            .i_led     (i_leds[i]),
            .i_pwm_cnt (pwm_cnt_q),
            .o_led     (o_ledr[i]),
            .o_pending (pending[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: fast-fade instance for ramp/reversal/bypass/reset, slow instance for duty.
module tb_led_fader;

    logic       clk;
    logic       rst_n;
    logic       en, en2;
    logic [9:0] leds, leds2;
    logic [9:0] ledr, ledr2;
    logic       busy, busy2;
    logic [7:0] b0, b0d;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    led_fader #(.N_LEDS(10), .PWM_BITS(8), .STEP_DIV(4), .FADE_STEP(64)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_leds    (leds),
        .i_enable  (en),
        .o_ledr    (ledr),
        .o_busy    (busy)
    );

    led_fader #(.N_LEDS(10), .PWM_BITS(8), .STEP_DIV(1024), .FADE_STEP(128)) u_duty (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_leds    (leds2),
        .i_enable  (en2),
        .o_ledr    (ledr2),
        .o_busy    (busy2)
    );

    assign b0  = dut.g_ch[0].u_ch.bright_q;
    assign b0d = u_duty.g_ch[0].u_ch.bright_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops one expected brightness per observed change of channel 0.
    task automatic watch_b(input int budget, input string tag);
        logic [7:0] prev;
        int n;
        prev = b0;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (b0 !== prev) begin
                int e;
                e = exp_q.pop_front();
                checks++;
                if (b0 !== 8'(e)) begin
                    errors++;
                    $display("FAIL %s brightness got %0d expected %0d", tag, b0, e);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_during_fade got %b expected 1", tag, busy);
                end
                prev = b0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout got %0d pending expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        leds  = '0;
        leds2 = '0;
        en    = 1'b1;
        en2   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ledr !== 10'h000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold ledr/busy got %h/%b expected 000/0", ledr, busy);
            end
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ledr !== 10'h000 || busy !== 1'b0 || b0 !== 8'd0) begin
                errors++;
                $display("FAIL reset_release ledr/busy/b got %h/%b/%0d expected 000/0/0",
                         ledr, busy, b0);
            end
        end
    endtask

    task automatic test_ramp();
        leds = 10'h001;
        exp_q.push_back(64);
        exp_q.push_back(128);
        exp_q.push_back(192);
        exp_q.push_back(255);
        watch_b(40, "ramp");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ramp_busy_at_max got %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_busy_after got %b expected 0", busy);
        end
        repeat (8) begin
            checks++;
            if (ledr !== 10'h001) begin
                errors++;
                $display("FAIL ramp_full_on ledr got %h expected 001", ledr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_duty();
        int n;
        int highs;
        leds2 = 10'h001;
        n = 0;
        while (b0d !== 8'd128 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (b0d !== 8'd128) begin
            errors++;
            $display("FAIL duty_tick brightness got %0d expected 128", b0d);
        end
        highs = 0;
        repeat (256) begin
            @(negedge clk);
            if (ledr2[0] === 1'b1) highs++;
        end
        checks++;
        if (highs != 128) begin
            errors++;
            $display("FAIL duty_count high_cycles got %0d expected 128", highs);
        end
        checks++;
        if (ledr2[9:1] !== 9'h000) begin
            errors++;
            $display("FAIL duty_others ledr got %h expected 000", ledr2[9:1]);
        end
        leds2 = '0;
    endtask

    task automatic test_reversal();
        leds = 10'h000;
        exp_q.push_back(191);
        exp_q.push_back(127);
        exp_q.push_back(63);
        exp_q.push_back(0);
        watch_b(40, "fall");
        @(negedge clk);
        leds = 10'h001;
        exp_q.push_back(64);
        exp_q.push_back(128);
        watch_b(40, "rev_up");
        leds = 10'h000;
        exp_q.push_back(64);
        exp_q.push_back(0);
        watch_b(40, "rev_down");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rev_busy_at_zero got %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ledr !== 10'h000 || b0 !== 8'd0) begin
            errors++;
            $display("FAIL rev_settle busy/ledr/b got %b/%h/%0d expected 0/000/0", busy, ledr, b0);
        end
    endtask

    task automatic test_bypass();
        en   = 1'b0;
        leds = 10'h3FF;
        @(negedge clk);
        checks++;
        if (ledr !== 10'h3FF) begin
            errors++;
            $display("FAIL bypass_latency ledr got %h expected 3ff", ledr);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || b0 !== 8'd255) begin
            errors++;
            $display("FAIL bypass_snap busy/b got %b/%0d expected 0/255", busy, b0);
        end
        en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (ledr !== 10'h3FF || busy !== 1'b0) begin
                errors++;
                $display("FAIL reenable_no_dip ledr/busy got %h/%b expected 3ff/0", ledr, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        en   = 1'b0;
        leds = 10'h000;
        @(negedge clk);
        @(negedge clk);
        en   = 1'b1;
        leds = 10'h001;
        exp_q.push_back(64);
        exp_q.push_back(128);
        exp_q.push_back(192);
        watch_b(40, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ledr !== 10'h000 || busy !== 1'b0 || b0 !== 8'd0) begin
            errors++;
            $display("FAIL async_reset ledr/busy/b got %h/%b/%0d expected 000/0/0", ledr, busy, b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(64);
        exp_q.push_back(128);
        watch_b(40, "post_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_duty();
        test_reversal();
        test_bypass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
